control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 96 +++++++++
 rtl/control_decode.sv | 105 ++++++++++
 rtl/control_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the control unit: state encoding, opcodes, ALU codes,
// the control-strobe bundle and small opcode helpers.
package cpu_pkg;

    typedef logic [3:0] state_t;
    typedef logic [4:0] opc_t;
    typedef logic [3:0] alu_t;

    // State encoding (RST, fetch T0..T2, execute T3..T7, HALT)
    localparam state_t S_RST  = 4'd0;
    localparam state_t S_T0   = 4'd1;
    localparam state_t S_T1   = 4'd2;
    localparam state_t S_T2   = 4'd3;
    localparam state_t S_T3   = 4'd4;
    localparam state_t S_T4   = 4'd5;
    localparam state_t S_T5   = 4'd6;
    localparam state_t S_T6   = 4'd7;
    localparam state_t S_T7   = 4'd8;
    localparam state_t S_HALT = 4'd9;

    // Opcodes
    localparam opc_t OP_LD   = 5'b00000;
    localparam opc_t OP_LDI  = 5'b00001;
    localparam opc_t OP_ST   = 5'b00010;
    localparam opc_t OP_ADD  = 5'b00011;
    localparam opc_t OP_SUB  = 5'b00100;
    localparam opc_t OP_AND  = 5'b01001;
    localparam opc_t OP_OR   = 5'b01010;
    localparam opc_t OP_ADDI = 5'b01011;
    localparam opc_t OP_ANDI = 5'b01100;
    localparam opc_t OP_ORI  = 5'b01101;
    localparam opc_t OP_BR   = 5'b10010;
    localparam opc_t OP_JR   = 5'b10011;
    localparam opc_t OP_JAL  = 5'b10100;
    localparam opc_t OP_IN   = 5'b10101;
    localparam opc_t OP_OUT  = 5'b10110;
    localparam opc_t OP_NOP  = 5'b11001;
    localparam opc_t OP_HALT = 5'b11010;

    // ALU operation codes
    localparam alu_t ALU_ADD = 4'b0000;
    localparam alu_t ALU_SUB = 4'b0001;
    localparam alu_t ALU_AND = 4'b0010;
    localparam alu_t ALU_OR  = 4'b0011;

    // Every control output of the unit, in one bundle
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic c_out;
        logic inport_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic con_in;
        logic outport_in;
        logic inc_pc;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        alu_t alu_op;
        logic run;
    } ctrl_t;

    // ALU function used by an arithmetic/logic opcode; address math is ADD
    function automatic alu_t alu_for(input opc_t op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            default:         return ALU_ADD;
        endcase
    endfunction

    // Final execute step of each instruction; after it the FSM refetches
    function automatic state_t last_step(input opc_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return S_T5;
            OP_LD, OP_ST:                     return S_T7;
            OP_BR:                            return S_T6;
            OP_JAL:                           return S_T4;
            default:                          return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: maps (state, latched opcode, con_ff) to every strobe.
module control_decode
    import cpu_pkg::*;
(
    input  state_t state_i,
    input  opc_t   opcode_i,
    input  logic   con_ff_i,
    output ctrl_t  ctrl_o
);

    logic is_alu3;
    logic is_imm;
    logic is_mem;

    assign is_alu3 = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
                     (opcode_i == OP_AND) || (opcode_i == OP_OR);
    assign is_imm  = (opcode_i == OP_ADDI) || (opcode_i == OP_ANDI) ||
                     (opcode_i == OP_ORI);
    assign is_mem  = (opcode_i == OP_LD) || (opcode_i == OP_ST);

    // Strobe table per state; steps beyond an instruction's last step stay 0
    always_comb begin
        ctrl_o     = '0;
        ctrl_o.run = (state_i != S_RST) && (state_i != S_HALT);
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1; ctrl_o.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in  = 1'b1;
                ctrl_o.read     = 1'b1; ctrl_o.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1;
            end
            S_T3: begin
                if (is_alu3 || is_imm) begin
                    ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1;
                end else if (is_mem || opcode_i == OP_LDI) begin
                    ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1;
                end else begin
                    case (opcode_i)
                        OP_BR: begin
                            ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_in = 1'b1;
                        end
                        OP_JR: begin
                            ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1;
                        end
                        OP_JAL: begin
                            ctrl_o.pc_out = 1'b1; ctrl_o.grb = 1'b1; ctrl_o.r_in = 1'b1;
                        end
                        OP_IN: begin
                            ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.outport_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.z_in = 1'b1;
                    ctrl_o.alu_op = alu_for(opcode_i);
                end else if (is_imm || is_mem || opcode_i == OP_LDI) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_in = 1'b1;
                    ctrl_o.alu_op = alu_for(opcode_i);
                end else if (opcode_i == OP_BR) begin
                    ctrl_o.pc_out = 1'b1; ctrl_o.y_in = 1'b1;
                end else if (opcode_i == OP_JAL) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu3 || is_imm || opcode_i == OP_LDI) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (is_mem) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.mar_in = 1'b1;
                end else if (opcode_i == OP_BR) begin
                    ctrl_o.c_out = 1'b1; ctrl_o.z_in = 1'b1; ctrl_o.alu_op = ALU_ADD;
                end
            end
            S_T6: begin
                if (opcode_i == OP_LD) begin
                    ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1;
                end else if (opcode_i == OP_ST) begin
                    ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.mdr_in = 1'b1;
                end else if (opcode_i == OP_BR && con_ff_i) begin
                    ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = 1'b1;
                end
            end
            S_T7: begin
                if (opcode_i == OP_LD) begin
                    ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1;
                end else if (opcode_i == OP_ST) begin
                    ctrl_o.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: fetch T0..T2, execute T3..T7, halt on
// request at instruction boundaries. Outputs decode from registered state.
module control_unit
    import cpu_pkg::*;
#(
    parameter int BITS     = 32,
    parameter int OPC_BITS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] IR,
    input  logic            con_ff,
    input  logic            stop,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Cout,
    output logic            InPortout,
    output logic            PCin,
    output logic            MARin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            CONin,
    output logic            OutPortin,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [3:0]      alu_op,
    output logic            run
);

    state_t state_q, state_d;
    opc_t   opcode_q;
    ctrl_t  ctrl;
    logic   ir_unused;

    // Operand fields are consumed by the datapath, not here
    assign ir_unused = ^IR[BITS-OPC_BITS-1:0];

    // Next-state: refetch after an instruction's last step unless stop is set
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = stop ? S_HALT : S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == last_step(opcode_q)) begin
                    if (opcode_q == OP_HALT || stop) state_d = S_HALT;
                    else                             state_d = S_T0;
                end else begin
                    state_d = state_q + 4'd1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // State register; reset overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // Opcode captured as the instruction is loaded into IR at the end of T2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                opcode_q <= '0;
        else if (state_q == S_T2)  opcode_q <= opc_t'(IR[BITS-1 -: OPC_BITS]);
    end

    control_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode_q),
        .con_ff_i (con_ff),
        .ctrl_o   (ctrl)
    );

    assign PCout     = ctrl.pc_out;
    assign Zlowout   = ctrl.zlow_out;
    assign MDRout    = ctrl.mdr_out;
    assign Cout      = ctrl.c_out;
    assign InPortout = ctrl.inport_out;
    assign PCin      = ctrl.pc_in;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign IRin      = ctrl.ir_in;
    assign Yin       = ctrl.y_in;
    assign Zin       = ctrl.z_in;
    assign CONin     = ctrl.con_in;
    assign OutPortin = ctrl.outport_in;
    assign IncPC     = ctrl.inc_pc;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign alu_op    = ctrl.alu_op;
    assign run       = ctrl.run;

endmodule
